mem_port_arbiter: RTL and testbench

Shares the single main-memory port between the instruction cache (read-only requester) and the data cache (read/write requester). Each side sees a private port with the codebase's READ/WRITE/BUSYWAIT handshake. The arbiter serialises requests into one-at-a-time block transactions on the memory port and returns read data to the winner. It sits between both caches and main memory, and drives the CPU stall sources INSTRUCTION_BUSYWAIT and BUSYWAIT through the caches.

---
 rtl/mem_port_arbiter.sv | 118 +++++++++++
 tb/tb_mem_port_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single main-memory port: icache (read-only) and
// dcache (read/write), round-robin on contention, one block transaction at a time.
module mem_port_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              I_READ,
    input  logic [ADDR_W-1:0] I_ADDRESS,
    output logic [DATA_W-1:0] I_READDATA,
    output logic              I_BUSYWAIT,
    input  logic              D_READ,
    input  logic              D_WRITE,
    input  logic [ADDR_W-1:0] D_ADDRESS,
    input  logic [DATA_W-1:0] D_WRITEDATA,
    output logic [DATA_W-1:0] D_READDATA,
    output logic              D_BUSYWAIT,
    output logic              M_READ,
    output logic              M_WRITE,
    output logic [ADDR_W-1:0] M_ADDRESS,
    output logic [DATA_W-1:0] M_WRITEDATA,
    input  logic [DATA_W-1:0] M_READDATA,
    input  logic              M_BUSYWAIT
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT_I = 3'd1,
        GRANT_D = 3'd2,
        DONE_I  = 3'd3,
        DONE_D  = 3'd4
    } state_t;

    state_t              state_q;
    logic                last_d_q;   // 1: dcache won the most recent grant
    logic                first_q;    // first GRANT cycle, completion is suppressed
    logic                m_read_q;
    logic                m_write_q;
    logic [ADDR_W-1:0]   m_addr_q;
    logic [DATA_W-1:0]   m_wdata_q;
    logic [DATA_W-1:0]   i_rdata_q;
    logic [DATA_W-1:0]   d_rdata_q;

    logic i_req, d_req, grant_i, mem_done;

    assign i_req    = I_READ;
    assign d_req    = D_READ | D_WRITE;
    assign grant_i  = i_req & (~d_req | last_d_q);
    assign mem_done = ~first_q & ~M_BUSYWAIT;

    assign I_BUSYWAIT  = i_req & (state_q != DONE_I);
    assign D_BUSYWAIT  = d_req & (state_q != DONE_D);
    assign I_READDATA  = i_rdata_q;
    assign D_READDATA  = d_rdata_q;
    assign M_READ      = m_read_q;
    assign M_WRITE     = m_write_q;
    assign M_ADDRESS   = m_addr_q;
    assign M_WRITEDATA = m_wdata_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= IDLE;
            last_d_q  <= 1'b1;
            first_q   <= 1'b0;
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_i) begin
                        m_read_q  <= 1'b1;
                        m_write_q <= 1'b0;
                        m_addr_q  <= I_ADDRESS;
                        last_d_q  <= 1'b0;
                        first_q   <= 1'b1;
                        state_q   <= GRANT_I;
                    end else if (d_req) begin
                        // write wins when both D strobes are high
                        m_read_q  <= ~D_WRITE;
                        m_write_q <= D_WRITE;
                        m_addr_q  <= D_ADDRESS;
                        m_wdata_q <= D_WRITEDATA;
                        last_d_q  <= 1'b1;
                        first_q   <= 1'b1;
                        state_q   <= GRANT_D;
                    end
                end
                GRANT_I: begin
                    first_q <= 1'b0;
                    if (mem_done) begin
                        m_read_q <= 1'b0;
                        if (i_req)
                            i_rdata_q <= M_READDATA;
                        state_q <= DONE_I;
                    end
                end
                GRANT_D: begin
                    first_q <= 1'b0;
                    if (mem_done) begin
                        m_read_q  <= 1'b0;
                        m_write_q <= 1'b0;
                        if (m_read_q && d_req)
                            d_rdata_q <= M_READDATA;
                        state_q <= DONE_D;
                    end
                end
                DONE_I, DONE_D: state_q <= IDLE;
                default:        state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table of single transactions plus
// hand sequences for contention, round-robin, dropped requests and async reset.
module tb_mem_port_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        I_READ;
    logic [5:0]  I_ADDRESS;
    logic [31:0] I_READDATA;
    logic        I_BUSYWAIT;
    logic        D_READ, D_WRITE;
    logic [5:0]  D_ADDRESS;
    logic [31:0] D_WRITEDATA;
    logic [31:0] D_READDATA;
    logic        D_BUSYWAIT;
    logic        M_READ, M_WRITE;
    logic [5:0]  M_ADDRESS;
    logic [31:0] M_WRITEDATA;
    logic [31:0] M_READDATA;
    logic        M_BUSYWAIT;

    int errors = 0;
    int checks = 0;

    int          mem_b = 0;
    logic [31:0] mem_rdata = '0;
    int          mem_cnt = 0;

    mem_port_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
        .CLK(CLK), .RESET(RESET),
        .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
        .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
        .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
        .M_READ(M_READ), .M_WRITE(M_WRITE), .M_ADDRESS(M_ADDRESS), .M_WRITEDATA(M_WRITEDATA),
        .M_READDATA(M_READDATA), .M_BUSYWAIT(M_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    // Memory model: busy for the first mem_b posedges after the strobe appears
    assign M_READDATA = mem_rdata;
    always @(negedge CLK) begin
        if (M_READ || M_WRITE) begin
            mem_cnt    = mem_cnt + 1;
            M_BUSYWAIT = (mem_cnt <= mem_b);
        end else begin
            mem_cnt    = 0;
            M_BUSYWAIT = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic        is_i;
        logic        rd;
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          busy;
        logic        exp_mr;
        logic        exp_mw;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int n;
        logic bw, d_dropped;
        int k, cyc, last_cyc;
        logic prev;
        logic [3:0] order;

        M_BUSYWAIT = 1'b0;
        RESET = 1'b0;
        I_READ = 0; I_ADDRESS = '0;
        D_READ = 0; D_WRITE = 0; D_ADDRESS = '0; D_WRITEDATA = '0;

        //          is_i rd wr addr   wdata         rdata         B  mr mw exp readdata
        vecs[0] = '{1'b1, 1, 0, 6'h05, 32'h0,        32'hDEADBEEF, 4, 1, 0, 32'hDEADBEEF};
        vecs[1] = '{1'b0, 0, 1, 6'h02, 32'h12345678, 32'hFFFFFFFF, 1, 0, 1, 32'h00000000};
        vecs[2] = '{1'b0, 1, 0, 6'h0A, 32'h0,        32'hCAFEF00D, 0, 1, 0, 32'hCAFEF00D};
        vecs[3] = '{1'b0, 1, 1, 6'h3F, 32'hA5A5A5A5, 32'h11111111, 2, 0, 1, 32'hCAFEF00D};
        vecs[4] = '{1'b1, 1, 0, 6'h3F, 32'h0,        32'h0BADF00D, 0, 1, 0, 32'h0BADF00D};

        #1;
        chk("rst_mread", M_READ, 0);
        chk("rst_mwrite", M_WRITE, 0);
        chk("rst_maddr", M_ADDRESS, 0);
        chk("rst_mwdata", M_WRITEDATA, 0);
        chk("rst_irdata", I_READDATA, 0);
        chk("rst_drdata", D_READDATA, 0);
        tick();
        RESET = 1'b1;
        tick();

        for (int v = 0; v < 5; v++) begin
            mem_b = vecs[v].busy;
            mem_rdata = vecs[v].rdata;
            if (vecs[v].is_i) begin
                I_READ = 1; I_ADDRESS = vecs[v].addr;
            end else begin
                D_READ = vecs[v].rd; D_WRITE = vecs[v].wr;
                D_ADDRESS = vecs[v].addr; D_WRITEDATA = vecs[v].wdata;
            end
            #1;
            chk($sformatf("v%0d_bw_same_cycle", v), vecs[v].is_i ? I_BUSYWAIT : D_BUSYWAIT, 1);
            n = 0;
            d_dropped = 0;
            do begin
                tick();
                n++;
                if (n == 1) begin
                    chk($sformatf("v%0d_mread", v), M_READ, vecs[v].exp_mr);
                    chk($sformatf("v%0d_mwrite", v), M_WRITE, vecs[v].exp_mw);
                    chk($sformatf("v%0d_maddr", v), M_ADDRESS, vecs[v].addr);
                    if (vecs[v].wr)
                        chk($sformatf("v%0d_mwdata", v), M_WRITEDATA, vecs[v].wdata);
                end
                bw = vecs[v].is_i ? I_BUSYWAIT : D_BUSYWAIT;
                if ((vecs[v].is_i ? D_BUSYWAIT : I_BUSYWAIT) !== 1'b0) d_dropped = 1;
            end while (bw && n < 50);
            // busy for B edges after the ignored first GRANT edge, then DONE
            chk($sformatf("v%0d_latency", v), n, ((vecs[v].busy < 1) ? 1 : vecs[v].busy) + 2);
            chk($sformatf("v%0d_other_bw", v), d_dropped, 0);
            chk($sformatf("v%0d_rdata", v), vecs[v].is_i ? I_READDATA : D_READDATA, vecs[v].exp_rd);
            chk($sformatf("v%0d_strobe_clr", v), {M_READ, M_WRITE}, 0);
            I_READ = 0; D_READ = 0; D_WRITE = 0;
            tick();
        end

        // I request dropped in the second GRANT cycle
        mem_b = 3; mem_rdata = 32'h99999999;
        I_READ = 1; I_ADDRESS = 6'h07;
        tick();
        chk("drop_mread_t0", M_READ, 1);
        tick();
        I_READ = 0;
        #1;
        chk("drop_ibw", I_BUSYWAIT, 0);
        tick();
        chk("drop_mread_held", M_READ, 1);
        n = 0;
        while (M_READ && n < 50) begin tick(); n++; end
        chk("drop_completes", M_READ, 0);
        chk("drop_irdata_kept", I_READDATA, 32'h0BADF00D);
        tick();
        tick();
        chk("drop_idle", {M_READ, M_WRITE}, 0);

        // Fresh reset, then simultaneous I read and D write: I wins first
        RESET = 0; #2; RESET = 1;
        tick();
        mem_b = 1; mem_rdata = 32'h77777777;
        I_READ = 1; I_ADDRESS = 6'h01;
        D_WRITE = 1; D_ADDRESS = 6'h02; D_WRITEDATA = 32'h12345678;
        n = 0; d_dropped = 0;
        do begin
            tick(); n++;
            if (n == 1) begin
                chk("sim_i_first", M_READ, 1);
                chk("sim_i_addr", M_ADDRESS, 6'h01);
            end
            if (!D_BUSYWAIT) d_dropped = 1;
        end while (I_BUSYWAIT && n < 50);
        chk("sim_dbw_held", d_dropped, 0);
        chk("sim_irdata", I_READDATA, 32'h77777777);
        I_READ = 0;
        n = 0;
        while (!M_WRITE && n < 50) begin tick(); n++; end
        chk("sim_d_write", M_WRITE, 1);
        chk("sim_d_addr", M_ADDRESS, 6'h02);
        chk("sim_d_wdata", M_WRITEDATA, 32'h12345678);
        n = 0;
        while (D_BUSYWAIT && n < 50) begin tick(); n++; end
        chk("sim_d_done", D_BUSYWAIT, 0);
        D_WRITE = 0;
        tick();

        // Both requesting continuously: alternation, grants 5 edges apart
        // (IDLE edge + 3 GRANT cycles + DONE with two busy edges)
        mem_b = 2; mem_rdata = 32'h0;
        I_READ = 1; I_ADDRESS = 6'h10;
        D_READ = 1; D_ADDRESS = 6'h20;
        k = 0; cyc = 0; last_cyc = 0; prev = 0; order = '0;
        while (k < 4 && cyc < 100) begin
            tick(); cyc++;
            if ((M_READ || M_WRITE) && !prev) begin
                order[k] = (M_ADDRESS == 6'h10);
                if (k > 0) chk($sformatf("rr_gap%0d", k), cyc - last_cyc, 5);
                last_cyc = cyc;
                k++;
            end
            prev = M_READ || M_WRITE;
        end
        chk("rr_order", {28'h0, order}, 32'h5);
        I_READ = 0; D_READ = 0;
        n = 0;
        while ((M_READ || M_WRITE) && n < 50) begin tick(); n++; end
        tick(); tick();

        // Async reset in the middle of a D write
        mem_b = 3;
        D_WRITE = 1; D_ADDRESS = 6'h2A; D_WRITEDATA = 32'h5555AAAA;
        tick();
        chk("ar_mwrite_pre", M_WRITE, 1);
        #2 RESET = 0;
        #1;
        chk("ar_mwrite_drop", M_WRITE, 0);
        chk("ar_mread", M_READ, 0);
        chk("ar_irdata", I_READDATA, 0);
        chk("ar_drdata", D_READDATA, 0);
        #1 RESET = 1;
        tick();
        chk("ar_regrant", M_WRITE, 1);
        chk("ar_regrant_addr", M_ADDRESS, 6'h2A);
        n = 0;
        while (D_BUSYWAIT && n < 50) begin tick(); n++; end
        chk("ar_done", D_BUSYWAIT, 0);
        D_WRITE = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
